// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
//   SEG7_LUT : 16-entry hex -> {g,f,e,d,c,b,a} pattern, active-low
//   AN_OFF   : all anodes deselected (active-low)
//   SEG_OFF  : all cathodes off, dp included (active-low)
//   div_w()  : width of the refresh divider counter
package seg7_pkg;

  // Index 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  function automatic int div_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble decoder.
//   nib : 4-bit hex value
//   seg : 7-bit active-low pattern {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG7_LUT[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A snapshot of {hexs, point, les} is taken once per frame (digit 0,
// divider 0), so the displayed value never mixes two count words. Each
// digit slot opens with BLANK_CYCLES of all-off to suppress ghosting.
//   clk     : board clock
//   rst_n   : asynchronous active-low reset
//   hexs    : four hex digits, [3:0] = digit 0 (rightmost)
//   point   : decimal point per digit, 1 = lit
//   les     : blank mask per digit, 1 = dark
//   an      : anode selects, active-low, an[0] = rightmost
//   segment : cathodes, active-low, {dp,g,f,e,d,c,b,a}
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] hexs,
  input  logic [3:0]  point,
  input  logic [3:0]  les,
  output logic [3:0]  an,
  output logic [7:0]  segment
);

  localparam int             DIV_W     = div_w(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        idx;
  logic [3:0][3:0]   snap_hexs;
  logic [3:0]        snap_point;
  logic [3:0]        snap_les;
  logic [3:0][6:0]   dig_seg;

  // One decoder per snapshot digit; the slot index just selects a result.
  for (genvar i = 0; i < 4; i++) begin : g_dec
    hex_to_seg7 u_dec (
      .nib (snap_hexs[i]),
      .seg (dig_seg[i])
    );
  end

  logic       blank_ph;
  logic       snap_en;
  logic [3:0] an_nxt;
  logic [7:0] seg_nxt;

  assign blank_ph = (div_cnt < BLANK_END);
  assign snap_en  = (idx == 2'd0) && (div_cnt == '0);

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    if (!blank_ph && !snap_les[idx]) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = {~snap_point[idx], dig_seg[idx]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      idx        <= 2'd0;
      snap_hexs  <= '0;
      snap_point <= '0;
      snap_les   <= '0;
      an         <= AN_OFF;
      segment    <= SEG_OFF;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (snap_en) begin
        snap_hexs  <= hexs;
        snap_point <= point;
        snap_les   <= les;
      end
      an      <= an_nxt;
      segment <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hexs = '0;
  logic [3:0]  point = '0;
  logic [3:0]  les = '0;
  logic [3:0]  an;
  logic [7:0]  segment;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // edges since last reset release

  // Hand-written hex -> {g..a} active-low table
  logic [6:0] exp_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hexs    (hexs),
    .point   (point),
    .les     (les),
    .an      (an),
    .segment (segment)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected display after edge 'cyc': 8-cycle slots, first 2 cycles dark.
  task automatic check_cycle(input logic [3:0][7:0] segs, input logic [3:0] dark);
    int pos, slot, ph;
    logic [3:0] ea;
    logic [7:0] es;
    pos  = (cyc - 1) % 32;
    slot = pos / 8;
    ph   = pos % 8;
    if (ph < 2 || dark[slot]) begin
      ea = 4'hF;
      es = 8'hFF;
    end else begin
      ea = ~(4'b0001 << slot);
      es = segs[slot];
    end
    chk($sformatf("an c%0d", cyc), {28'd0, an}, {28'd0, ea});
    chk($sformatf("seg c%0d", cyc), {24'd0, segment}, {24'd0, es});
    chk($sformatf("onehot c%0d", cyc), {31'd0, ($countones(~an) <= 1)}, 32'd1);
  endtask

  task automatic run_frame(input logic [3:0][7:0] segs, input logic [3:0] dark);
    int lit = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      check_cycle(segs, dark);
      if (an != 4'hF) lit++;
    end
    chk("lit cycles", lit, 6 * (4 - $countones(dark)));
  endtask

  initial begin
    // Reset state
    hexs = 16'h12AF; point = 4'b0000; les = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst an", {28'd0, an}, 32'hF);
    chk("rst seg", {24'd0, segment}, 32'hFF);
    rst_n = 1'b1;
    cyc = 0;

    // 12AF: F->8E, A->88, 2->A4, 1->F9
    run_frame({8'hF9, 8'hA4, 8'h88, 8'h8E}, 4'b0000);

    // Decimal point on digit 1
    point = 4'b0010; hexs = 16'h0080;
    run_frame({8'hC0, 8'hC0, 8'h00, 8'hC0}, 4'b0000);

    // Blank mask on digits 2,3
    point = 4'b0000; les = 4'b1100; hexs = 16'h8888;
    run_frame({8'h80, 8'h80, 8'h80, 8'h80}, 4'b1100);

    // Tearing: change mid-slot 2, frame must stay on the old snapshot
    les = 4'b0000; hexs = 16'h1111;
    for (int k = 0; k < 32; k++) begin
      tick();
      check_cycle({8'hF9, 8'hF9, 8'hF9, 8'hF9}, 4'b0000);
      if ((cyc - 1) % 32 == 19) hexs = 16'h2222;
    end
    run_frame({8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b0000);

    // Full LUT sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      hexs = {12'h000, 4'(v)};
      run_frame({8'hC0, 8'hC0, 8'hC0, {1'b1, exp_lut[v]}}, 4'b0000);
    end

    // Reset in slot 3 DRIVE; 1234: 4->99, 3->B0, 2->A4, 1->F9
    hexs = 16'h1234;
    for (int k = 0; k < 28; k++) begin
      tick();
      check_cycle({8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b0000);
    end
    chk("pre-rst lit", {28'd0, an}, 32'h7);
    rst_n = 1'b0;
    #1;
    chk("async an", {28'd0, an}, 32'hF);
    chk("async seg", {24'd0, segment}, 32'hFF);
    repeat (2) @(posedge clk);
    #1;
    chk("held an", {28'd0, an}, 32'hF);
    hexs = 16'h0005;
    rst_n = 1'b1;
    cyc = 0;
    // 5 -> 12 with dp off -> 92; first lit edge is 3
    run_frame({8'hC0, 8'hC0, 8'hC0, 8'h92}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
